ctrl_seq_unit: RTL
==================

// Module: ctrl_seq_unit
// PURPOSE
//  Parametrised hardwired control sequencer for the model computer; successor to the fixed T0..T7 decoder.
//  Owns its timing generator (phase counter -> one-hot T bus), latches the opcode, ends each instruction early
//  (LD, HALT, illegal), and stops on HALT. Drives MAR/DR/PC/IR/A/ALU strobes of the single-bus datapath.
// PARAMETERS
//  OPC_W     4  opcode width (>=4)
//  T_STATES  8  one-hot T bus width (>=8; phases above T7 unused, always 0)
//  ALU_OP_W  3  width of alu_op select
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         synchronous, active-high reset
//  run          in   1         level: 1 = fetch/execute, 0 = stop at next instruction boundary
//  opcode       in   OPC_W     IR opcode field; valid from T3 of each instruction
//  t_state      out  T_STATES  one-hot current phase (all-zero when idle/halted)
//  mar_ld       out  1         load MAR from bus
//  dr_ld        out  1         load DR from memory
//  dr_oe        out  1         DR drives bus / ALU B
//  ir_ld        out  1         load IR
//  pc_inc       out  1         PC <= PC+1
//  pc_ld        out  1         PC <= bus (JMP only)
//  a_ld         out  1         load accumulator A
//  a_oe         out  1         A drives bus
//  alu_oe       out  1         ALU result drives bus
//  alu_op       out  ALU_OP_W  0 ADD,1 SUB,2 AND,3 OR,4 SHL,5 XOR
//  halted       out  1         sticky HALT indication
//  illegal      out  1         1-cycle pulse: undefined opcode decoded
// BEHAVIOUR
//  - All strobes active-high; datapath-side inversion lives in the top level. Strobes are combinational from registered state.
//  - Reset: state IDLE, phase 0, op_q 0; every output 0 (t_state all-zero, alu_op 0). rst mid-instruction aborts at once.
//  - FSM: IDLE -(run)-> EXEC(T0); EXEC advances one phase per clk; last phase -> T0 if run else IDLE;
//    HALT at T3 -> HALTED (halted=1 next cycle, all strobes 0); only rst leaves HALTED.
//  - run sampled only at last phase (and in IDLE); deassertion never truncates an instruction.
//  - opcode used combinationally at T3, registered into op_q at end of T3; T4..T7 decode from op_q.
//  - Fetch (all): T0 mar_ld; T1 dr_ld; T2 ir_ld+pc_inc.
//  - Memory-operand ops (LD, ALU): T3 mar_ld; T4 dr_ld; T5 pc_inc, alu_op valid for ALU ops.
//  - LD: T6 dr_oe+a_ld; last phase = T6 (7 cycles).
//  - ALU: T6 dr_oe+alu_oe+a_ld; T7 a_oe+dr_oe (result written back); last phase = T7 (8 cycles).
//  - HALT: ends at T3 (4 cycles). Undefined opcode: illegal pulses in T3, no strobes, last phase = T3.
//  - alu_op held 0 except T5..T6 of ALU ops. Two strobes never drive the bus in one cycle except listed pairs.
// CONFIGURATION
//  - CTRL_JMP_EN defined: opcode JMP(8): T3 mar_ld; T4 dr_ld; T5 dr_oe+pc_ld (no pc_inc); last phase = T5 (6 cycles).
//  - CTRL_JMP_EN undefined: pc_ld tied 0; opcode 8 treated as illegal.
// STRUCTURE
//  - Package ctrl_pkg: opcode localparams (LD 0,ADD 1,SUB 2,AND 3,OR 4,SHL 5,XOR 6,HALT 7,JMP 8),
//    ALU op codes, FSM state encoding (IDLE/EXEC/HALTED), phase index constants T0..T7.
//  - Sub-module ctrl_phase_gen: phase counter + one-hot T bus, inputs adv/last/clr; top holds FSM + decode.
// TESTING
//  - rst held 3 cycles, run=1 -> all outputs 0 during reset; t_state=0x01, mar_ld=1 first cycle after release.
//  - ADD (1) with run=1 -> 8-cycle sequence; T5 alu_op=0; T6 alu_oe,a_ld,dr_oe; T7 a_oe,dr_oe; next T0.
//  - LD (0) then XOR (6) back-to-back -> 7 then 8 cycles, no gap; a_ld in T6 of both, alu_op=5 in T5/T6 of XOR only.
//  - HALT (7) -> after T3 halted=1, t_state=0 and no strobes for 20 cycles; rst -> halted=0, IDLE.
//  - opcode 8: with CTRL_JMP_EN -> pc_ld in T5, 6 cycles; without -> illegal pulse in T3, 4 cycles, pc_ld never 1.
//  - run dropped at T4 of SUB -> instruction completes through T7, then IDLE; run re-raised -> T0 next cycle.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Holds opcode/ALU encodings, FSM states, phase indices and small decode helpers.
// No logic of its own.
package ctrl_pkg;

    // Opcode values
    localparam int OP_LD   = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_SHL  = 5;
    localparam int OP_XOR  = 6;
    localparam int OP_HALT = 7;
    localparam int OP_JMP  = 8;

    // ALU select codes
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SHL = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;

    // Phase index width and phase constants
    localparam int PH_W = 3;
    localparam logic [PH_W-1:0] T0 = 3'd0;
    localparam logic [PH_W-1:0] T1 = 3'd1;
    localparam logic [PH_W-1:0] T2 = 3'd2;
    localparam logic [PH_W-1:0] T3 = 3'd3;
    localparam logic [PH_W-1:0] T4 = 3'd4;
    localparam logic [PH_W-1:0] T5 = 3'd5;
    localparam logic [PH_W-1:0] T6 = 3'd6;
    localparam logic [PH_W-1:0] T7 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Instruction classes; everything after fetch is decided by the class
    typedef enum logic [2:0] {
        CL_LD   = 3'd0,
        CL_ALU  = 3'd1,
        CL_HALT = 3'd2,
        CL_JMP  = 3'd3,
        CL_ILL  = 3'd4
    } op_class_t;

    function automatic op_class_t classify(input int op, input bit jmp_en);
        if (op == OP_LD)                     return CL_LD;
        if (op >= OP_ADD && op <= OP_XOR)    return CL_ALU;
        if (op == OP_HALT)                   return CL_HALT;
        if (op == OP_JMP && jmp_en)          return CL_JMP;
        return CL_ILL;
    endfunction

    // Final phase of each class; never below T3 so fetch phases are never "last"
    function automatic logic [PH_W-1:0] last_phase(input op_class_t c);
        case (c)
            CL_LD:   return T6;
            CL_ALU:  return T7;
            CL_JMP:  return T5;
            default: return T3;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input int op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHL:  return ALU_SHL;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_phase_gen.sv
// Phase counter plus one-hot T bus for the control sequencer.
// Latency: phase updates one cycle after adv; T bus is a pure decode of the counter.
// No backpressure: advances whenever adv is high, wraps to T0 when last is also high.
module ctrl_phase_gen
    import ctrl_pkg::*;
#(
    parameter int T_STATES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_adv,
    input  logic                i_last,
    input  logic                i_clr,
    output logic [PH_W-1:0]     o_phase,
    output logic [T_STATES-1:0] o_t_bus
);

    logic [PH_W-1:0] r_phase;

    // Phase counter: clear wins, otherwise step or wrap at the final phase
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_phase <= T0;
        end else if (i_adv) begin
            r_phase <= i_last ? T0 : r_phase + 1'b1;
        end
    end

    assign o_phase = r_phase;
    // Counter never exceeds T7, so bits above T7 stay 0
    assign o_t_bus = {{(T_STATES-1){1'b0}}, 1'b1} << r_phase;

endmodule

// File: rtl/ctrl_seq_unit.sv
// Hardwired control sequencer: FSM + per-phase strobe decode over ctrl_phase_gen.
// Latency: strobes combinational from registered state/phase; opcode sampled combinationally in T3.
// No backpressure; run only gates instruction boundaries. Optional JMP via CTRL_JMP_EN.
module ctrl_seq_unit
    import ctrl_pkg::*;
#(
    parameter int OPC_W    = 4,
    parameter int T_STATES = 8,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPC_W-1:0]    opcode,
    output logic [T_STATES-1:0] t_state,
    output logic                mar_ld,
    output logic                dr_ld,
    output logic                dr_oe,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                a_ld,
    output logic                a_oe,
    output logic                alu_oe,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                illegal
);

`ifdef CTRL_JMP_EN
    localparam bit JMP_EN = 1'b1;
`else
    localparam bit JMP_EN = 1'b0;
`endif

    state_t              r_state;
    state_t              w_next;
    logic [OPC_W-1:0]    r_op;
    logic [OPC_W-1:0]    w_op;
    logic [PH_W-1:0]     w_phase;
    logic [T_STATES-1:0] w_tbus;
    op_class_t           w_cls;
    logic                w_exec;
    logic                w_last;
    logic                w_mem;

    assign w_exec = (r_state == ST_EXEC);
    // T3 decodes the live IR field; later phases use the copy latched at the end of T3
    assign w_op   = (w_phase == T3) ? opcode : r_op;
    assign w_cls  = classify(int'(w_op), JMP_EN);
    assign w_mem  = (w_cls == CL_LD) || (w_cls == CL_ALU) || (w_cls == CL_JMP);
    assign w_last = w_exec && (w_phase == last_phase(w_cls));

    ctrl_phase_gen #(
        .T_STATES (T_STATES)
    ) u_phase_gen (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_exec),
        .i_last  (w_last),
        .i_clr   (!w_exec),
        .o_phase (w_phase),
        .o_t_bus (w_tbus)
    );

    assign t_state = w_exec ? w_tbus : '0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode latch at the end of T3
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op <= '0;
        end else if (w_exec && (w_phase == T3)) begin
            r_op <= opcode;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next  = r_state;
        mar_ld  = 1'b0;
        dr_ld   = 1'b0;
        dr_oe   = 1'b0;
        ir_ld   = 1'b0;
        pc_inc  = 1'b0;
        pc_ld   = 1'b0;
        a_ld    = 1'b0;
        a_oe    = 1'b0;
        alu_oe  = 1'b0;
        alu_op  = '0;
        halted  = 1'b0;
        illegal = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_next = ST_EXEC;
            end
            ST_EXEC: begin
                case (w_phase)
                    T0: mar_ld = 1'b1;
                    T1: dr_ld  = 1'b1;
                    T2: begin
                        ir_ld  = 1'b1;
                        pc_inc = 1'b1;
                    end
                    T3: begin
                        if (w_cls == CL_ILL) illegal = 1'b1;
                        else if (w_mem)      mar_ld  = 1'b1;
                    end
                    T4: begin
                        if (w_mem) dr_ld = 1'b1;
                    end
                    T5: begin
                        if (w_cls == CL_LD || w_cls == CL_ALU) pc_inc = 1'b1;
                        if (w_cls == CL_ALU) alu_op = ALU_OP_W'(alu_code(int'(w_op)));
`ifdef CTRL_JMP_EN
                        if (w_cls == CL_JMP) begin
                            dr_oe = 1'b1;
                            pc_ld = 1'b1;
                        end
`endif
                    end
                    T6: begin
                        if (w_cls == CL_LD) begin
                            dr_oe = 1'b1;
                            a_ld  = 1'b1;
                        end else if (w_cls == CL_ALU) begin
                            dr_oe  = 1'b1;
                            alu_oe = 1'b1;
                            a_ld   = 1'b1;
                            alu_op = ALU_OP_W'(alu_code(int'(w_op)));
                        end
                    end
                    T7: begin
                        if (w_cls == CL_ALU) begin
                            a_oe  = 1'b1;
                            dr_oe = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (w_last) begin
                    if (w_cls == CL_HALT) w_next = ST_HALTED;
                    else if (!run)        w_next = ST_IDLE;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
